write_back_buffer: RTL

WRITE_BACK_BUFFER -- requirements
Module: write_back_buffer

---
 rtl/write_back_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/write_back_buffer.sv
// Write-back buffer between the cache and main memory: in-order FIFO with read forwarding.
// Optional same-address write coalescing is enabled by defining WBUF_COALESCE_EN.
module write_back_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_fwd,
  output logic [ADDR_W-1:0]      mem_address_read,
  input  logic [DATA_W-1:0]      mem_readed,
  output logic                   mem_write,
  output logic [ADDR_W-1:0]      mem_address_write,
  output logic [DATA_W-1:0]      mem_data_write,
  input  logic                   hold,
  input  logic                   flush_req,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e            state_q;
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              flush_done_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              push, pop, alloc, hit;
  logic [PtrW-1:0]   hit_idx;

  assign count             = count_q;
  assign flush_done        = flush_done_q;
  assign mem_address_read  = rd_addr;
  assign mem_address_write = addr_q[head_q];
  assign mem_data_write    = data_q[head_q];
  // Hold only throttles draining in normal operation; a flush always drains.
  assign mem_write         = (count_q != '0) && (!hold || state_q == StFlush);
  assign pop               = mem_write;

`ifdef WBUF_COALESCE_EN
  // The head entry leaving this cycle cannot absorb a write; it would be lost.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx     = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (addr_q[idx] == wr_addr) && !(pop && k == 0)) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif

  assign wr_ready = (state_q == StRun) && ((count_q < CntW'(DEPTH)) || hit);
  assign push     = wr_valid && wr_ready;
  assign alloc    = push && !hit;
  assign count_d  = count_q + CntW'(alloc) - CntW'(pop);

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PtrW-1:0] idx;
    idx     = '0;
    rd_data = mem_readed;
    rd_fwd  = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_q + PtrW'(k);
      if ((CntW'(k) < count_q) && (addr_q[idx] == rd_addr)) begin
        rd_data = data_q[idx];
        rd_fwd  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      flush_done_q <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (alloc) begin
        tail_q <= tail_q + 1'b1;
      end
      count_q      <= count_d;
      flush_done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (flush_req) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (count_d == '0) begin
            state_q      <= StDone;
            flush_done_q <= 1'b1;
          end
        end
        StDone:  state_q <= StRun;
        default: state_q <= StRun;
      endcase
    end
  end

  // Entry storage needs no reset; validity is defined by head and count.
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[tail_q] <= wr_addr;
      data_q[tail_q] <= wr_data;
    end
    if (push && hit) begin
      data_q[hit_idx] <= wr_data;
    end
  end

endmodule
